// File: rtl/down_counter8b_pkg.sv
// down_counter8b_pkg
// Shared definitions for the loadable 8-bit down-counter/timer:
//   state_t : controller states (IDLE, RUN, DONE)
//   WIDTH   : counter width in bits (only 8 is verified)
package down_counter8b_pkg;

  localparam int WIDTH = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : down_counter8b_pkg

// File: rtl/down_counter8b_if.sv
// down_counter8b_if
// Control/status bundle of the down-counter.
//   clr  : synchronous clear to idle with a zero count
//   load : capture D as the start value
//   D    : start value
//   en   : count enable
//   Q    : current count (registered)
//   busy : high while counting
//   done : one-cycle pulse when the count reaches zero
// master drives the controls (testbench / host), slave is the counter.
interface down_counter8b_if #(
  parameter int WIDTH = down_counter8b_pkg::WIDTH
);
  logic             clr;
  logic             load;
  logic [WIDTH-1:0] D;
  logic             en;
  logic [WIDTH-1:0] Q;
  logic             busy;
  logic             done;

  modport master (
    output clr, load, D, en,
    input  Q, busy, done
  );

  modport slave (
    input  clr, load, D, en,
    output Q, busy, done
  );
endinterface : down_counter8b_if

// File: rtl/down_counter8b_decrementer8b.sv
// decrementer8b
// Combinational decrement used by the down-counter.
//   A    : operand
//   S    : A - 1 (wraps to all ones when A is zero)
//   Bout : borrow out, high exactly when A is zero
module decrementer8b #(
  parameter int W = down_counter8b_pkg::WIDTH
) (
  input  logic [W-1:0] A,
  output logic [W-1:0] S,
  output logic         Bout
);

  assign S    = A - W'(1);
  assign Bout = (A == '0);

endmodule : decrementer8b

// File: rtl/down_counter8b.sv
// down_counter8b
// Loadable down-counter/timer. A load captures a start value, the count
// drops by one per enabled cycle, and done pulses for one cycle at zero.
//   clk  : clock, rising edge
//   rst  : asynchronous, active-high reset
//   bus  : down_counter8b_if.slave (clr, load, D, en -> Q, busy, done)
// Optional feature: define DOWN_COUNTER8B_RELOAD_EN to add a reload
// register that restarts the count from the last loaded value after each
// DONE, giving a periodic done pulse until clr.
//
// state | meaning
// IDLE  | count held, en ignored, waiting for load
// RUN   | decrementing on each enabled cycle, busy=1
// DONE  | count is zero, done=1 for this single cycle
module down_counter8b #(
  parameter int WIDTH = down_counter8b_pkg::WIDTH
) (
  input  logic            clk,
  input  logic            rst,
  down_counter8b_if.slave bus
);
  import down_counter8b_pkg::*;

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] q;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] dec_s;
  logic             dec_borrow;

`ifdef DOWN_COUNTER8B_RELOAD_EN
  logic [WIDTH-1:0] reload;
`endif

  decrementer8b #(.W(WIDTH)) u_dec (
    .A    (q),
    .S    (dec_s),
    .Bout (dec_borrow)
  );

  // busy/done are registered alongside the state so they always equal the
  // decode of the state register without any output glitches.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      q      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
`ifdef DOWN_COUNTER8B_RELOAD_EN
      reload <= '0;
`endif
    end else if (bus.clr) begin
      state  <= IDLE;
      q      <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (bus.load) begin
      q <= bus.D;
`ifdef DOWN_COUNTER8B_RELOAD_EN
      reload <= bus.D;
`endif
      if (bus.D == '0) begin
        state  <= DONE;
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        state  <= RUN;
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      case (state)
        IDLE: begin
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
        RUN: begin
          if (bus.en) begin
            // A zero count never reaches RUN; the borrow guard only keeps
            // the count from wrapping should that ever be violated.
            if (dec_borrow) begin
              state  <= DONE;
              busy_r <= 1'b0;
              done_r <= 1'b1;
            end else begin
              q <= dec_s;
              if (q == ONE) begin
                state  <= DONE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end
            end
          end
        end
        DONE: begin
`ifdef DOWN_COUNTER8B_RELOAD_EN
          if (reload != '0) begin
            q      <= reload;
            state  <= RUN;
            busy_r <= 1'b1;
            done_r <= 1'b0;
          end else begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
          end
`else
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b0;
`endif
        end
        default: begin
          state  <= IDLE;
          q      <= '0;
          busy_r <= 1'b0;
          done_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.busy = busy_r;
  assign bus.done = done_r;

endmodule : down_counter8b

// File: tb/tb_down_counter8b.sv
module tb_down_counter8b;

  logic clk;
  logic rst;

  down_counter8b_if bus ();

  down_counter8b dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [7:0] dec_a;
  logic [7:0] dec_s;
  logic       dec_bout;

  decrementer8b u_dec_unit (
    .A    (dec_a),
    .S    (dec_s),
    .Bout (dec_bout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: phase 0 = idle, 1 = counting, 2 = zero reached.
  int m_q;
  int m_phase;
  int m_reload;

  function automatic logic exp_busy();
    return (m_phase == 1);
  endfunction

  function automatic logic exp_done();
    return (m_phase == 2);
  endfunction

  task automatic model_reset();
    m_q = 0;
    m_phase = 0;
    m_reload = 0;
  endtask

  task automatic model_edge(input logic c, input logic l, input int d, input logic e);
    if (c) begin
      m_q = 0;
      m_phase = 0;
    end else if (l) begin
      m_q = d;
      m_reload = d;
      m_phase = (d == 0) ? 2 : 1;
    end else if (m_phase == 1) begin
      if (e) begin
        m_q = m_q - 1;
        if (m_q == 0) m_phase = 2;
      end
    end else if (m_phase == 2) begin
`ifdef DOWN_COUNTER8B_RELOAD_EN
      if (m_reload != 0) begin
        m_q = m_reload;
        m_phase = 1;
      end else begin
        m_phase = 0;
      end
`else
      m_phase = 0;
`endif
    end
  endtask

  // Advance one clock edge; model sees the inputs as they stood at the edge.
  task automatic step();
    @(posedge clk);
    model_edge(bus.clr, bus.load, int'(bus.D), bus.en);
    #1;
  endtask

  task automatic drive(input logic c, input logic l, input logic [7:0] d, input logic e);
    bus.clr = c;
    bus.load = l;
    bus.D = d;
    bus.en = e;
  endtask

  task automatic test_reset();
    drive(0, 0, 8'd0, 0);
    rst = 1'b1;
    model_reset();
    #12;
    checks++;
    if (bus.Q !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: Q=%0d busy=%b done=%b, required Q=0 busy=0 done=0",
               bus.Q, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive(0, 1, 8'd5, 1);
    step();
    drive(0, 0, 8'd0, 1);
    checks++;
    if (bus.Q !== 8'd5 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_preload: Q=%0d busy=%b, required Q=5 busy=1", bus.Q, bus.busy);
    end
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    checks++;
    if (bus.Q !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: Q=%0d busy=%b done=%b, required Q=0 busy=0 done=0",
               bus.Q, bus.busy, bus.done);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (bus.Q !== 8'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_stays_idle: Q=%0d busy=%b, required Q=0 busy=0", bus.Q, bus.busy);
    end
    drive(0, 1, 8'd0, 1);
    step();
    drive(0, 0, 8'd0, 1);
    checks++;
    if (bus.done !== 1'b1 || bus.Q !== 8'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_zero_done: done=%b Q=%0d busy=%b, required done=1 Q=0 busy=0",
               bus.done, bus.Q, bus.busy);
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL load_zero_pulse_end: done=%b busy=%b, required done=0 busy=0",
               bus.done, bus.busy);
    end
  endtask

  task automatic test_basic_count();
    int exp_q[5] = '{3, 2, 1, 0, 0};
    logic exp_b[5] = '{1, 1, 1, 0, 0};
    logic exp_d[5] = '{0, 0, 0, 1, 0};
    drive(0, 1, 8'd3, 1);
    for (int i = 0; i < 5; i++) begin
      step();
      drive(0, 0, 8'd0, 1);
      checks++;
      if (bus.Q !== 8'(exp_q[i]) || bus.busy !== exp_b[i] || bus.done !== exp_d[i]) begin
        errors++;
        $display("FAIL basic_count[%0d]: Q=%0d busy=%b done=%b, required Q=%0d busy=%b done=%b",
                 i, bus.Q, bus.busy, bus.done, exp_q[i], exp_b[i], exp_d[i]);
      end
    end
  endtask

  task automatic test_enable_gaps();
    int done_at = -1;
    drive(0, 1, 8'd4, 1);
    step();
    for (int i = 1; i <= 10; i++) begin
      drive(0, 0, 8'd0, (i % 2) == 1);
      step();
      checks++;
      if (bus.Q !== 8'(m_q) || bus.done !== exp_done() || bus.busy !== exp_busy()) begin
        errors++;
        $display("FAIL enable_gaps[%0d]: Q=%0d busy=%b done=%b, required Q=%0d busy=%b done=%b",
                 i, bus.Q, bus.busy, bus.done, m_q, exp_busy(), exp_done());
      end
      if (bus.done === 1'b1 && done_at < 0) done_at = i;
    end
    checks++;
    if (done_at != 7) begin
      errors++;
      $display("FAIL enable_gaps_latency: done after %0d cycles, required 7", done_at);
    end
    drive(1, 0, 8'd0, 0);
    step();
  endtask

  task automatic test_restart_priority();
    drive(0, 1, 8'd10, 1);
    step();
    drive(0, 0, 8'd0, 1);
    repeat (3) step();
    checks++;
    if (bus.Q !== 8'd7) begin
      errors++;
      $display("FAIL restart_pre: Q=%0d, required 7", bus.Q);
    end
    drive(0, 1, 8'd2, 1);
    step();
    checks++;
    if (bus.Q !== 8'd2 || bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_load_wins: Q=%0d busy=%b, required Q=2 busy=1", bus.Q, bus.busy);
    end
    drive(1, 1, 8'd9, 1);
    step();
    drive(0, 0, 8'd0, 1);
    checks++;
    if (bus.Q !== 8'd0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL clr_beats_load: Q=%0d busy=%b done=%b, required Q=0 busy=0 done=0",
               bus.Q, bus.busy, bus.done);
    end
    step();
    checks++;
    if (bus.Q !== 8'd0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle_hold: Q=%0d busy=%b, required Q=0 busy=0", bus.Q, bus.busy);
    end
  endtask

  task automatic test_load_in_done();
    drive(0, 1, 8'd1, 1);
    step();
    drive(0, 0, 8'd0, 1);
    step();
    drive(0, 1, 8'd3, 1);
    checks++;
    if (bus.done !== 1'b1) begin
      errors++;
      $display("FAIL done_before_reload: done=%b, required 1", bus.done);
    end
    step();
    drive(0, 0, 8'd0, 1);
    checks++;
    if (bus.Q !== 8'd3 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL load_in_done: Q=%0d busy=%b done=%b, required Q=3 busy=1 done=0",
               bus.Q, bus.busy, bus.done);
    end
    drive(1, 0, 8'd0, 0);
    step();
  endtask

  task automatic test_reload();
    int pulses = 0;
    int wrong_at = 0;
    drive(0, 1, 8'd2, 1);
    step();
    drive(0, 0, 8'd0, 1);
    for (int i = 1; i <= 12; i++) begin
      step();
      if (bus.done === 1'b1) pulses++;
`ifdef DOWN_COUNTER8B_RELOAD_EN
      if (bus.done !== ((i % 3) == 2)) wrong_at++;
`else
      if (bus.done !== (i == 2)) wrong_at++;
`endif
    end
    checks++;
    if (wrong_at != 0) begin
      errors++;
      $display("FAIL reload_pattern: %0d cycles with wrong done, %0d pulses seen", wrong_at, pulses);
    end
    drive(1, 0, 8'd0, 1);
    step();
    drive(0, 0, 8'd0, 1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      step();
      if (bus.done === 1'b1 || bus.busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 0 || bus.Q !== 8'd0) begin
      errors++;
      $display("FAIL reload_clr_stop: %0d active cycles after clr Q=%0d, required 0 and Q=0",
               pulses, bus.Q);
    end
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0,
            8'($urandom_range(0, 12)),
            $urandom_range(0, 3) != 0);
      step();
      checks++;
      if (bus.Q !== 8'(m_q) || bus.busy !== exp_busy() || bus.done !== exp_done()) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL random[%0d]: Q=%0d busy=%b done=%b, required Q=%0d busy=%b done=%b",
                   i, bus.Q, bus.busy, bus.done, m_q, exp_busy(), exp_done());
      end
    end
    drive(1, 0, 8'd0, 0);
    step();
  endtask

  task automatic test_decrementer();
    logic [7:0] vec_a[3] = '{8'h00, 8'h01, 8'h10};
    logic [7:0] vec_s[3] = '{8'hFF, 8'h00, 8'h0F};
    logic       vec_b[3] = '{1'b1, 1'b0, 1'b0};
    for (int i = 0; i < 3; i++) begin
      dec_a = vec_a[i];
      #1;
      checks++;
      if (dec_s !== vec_s[i] || dec_bout !== vec_b[i]) begin
        errors++;
        $display("FAIL dec_vector[%0d]: S=%h Bout=%b, required S=%h Bout=%b",
                 i, dec_s, dec_bout, vec_s[i], vec_b[i]);
      end
    end
    for (int i = 0; i < 20; i++) begin
      int a;
      a = $urandom_range(0, 255);
      dec_a = 8'(a);
      #1;
      checks++;
      if (dec_s !== 8'((a + 255) % 256) || dec_bout !== (a == 0)) begin
        errors++;
        $display("FAIL dec_random: A=%h S=%h Bout=%b, required S=%h Bout=%b",
                 dec_a, dec_s, dec_bout, 8'((a + 255) % 256), (a == 0));
      end
    end
  endtask

  initial begin
    dec_a = 8'h00;
    rst = 1'b0;
    drive(0, 0, 8'd0, 0);
    test_reset();
    test_basic_count();
    test_enable_gaps();
    test_restart_priority();
    test_load_in_done();
    test_reload();
    test_random();
    test_decrementer();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_down_counter8b
